// File: rtl/chatter_counter.sv
// chatter_counter: debounces one mechanical push-button.
//
// A raw, asynchronous, bouncing button input is synchronised through two flops
// and then qualified by a stability counter. A new level is accepted only after
// it has been seen on every one of DEBOUNCE_CYCLES consecutive edges. Press and
// release are qualified the same way. A toggle flop flips on each qualified
// press, giving a press-to-toggle enable.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a level (>= 1)
//   CNT_WIDTH        stability counter width, 2**CNT_WIDTH > DEBOUNCE_CYCLES-1
//
// Ports:
//   chatterclock  in   system clock, rising edge
//   reset         in   asynchronous active-high reset, clears all state to 0
//   switchin      in   raw button input, 1 = pressed
//   ispressed     out  debounced level, registered
//   enabled       out  toggle state, flips on each debounced press, registered
//
// Build option:
//   CHATTER_ACTIVE_LOW_EN  when defined, switchin is inverted before the
//                          synchroniser (pull-up buttons, 0 at the pin = pressed).
//                          Reset values stay 0 ("not pressed").

module chatter_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_WIDTH       = 18
) (
    input  logic chatterclock,
    input  logic reset,
    input  logic switchin,
    output logic ispressed,
    output logic enabled
);

    localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sw_in;
    logic                 sync1_q;
    logic                 sync2_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 pressed_d;
    logic                 enabled_d;

`ifdef CHATTER_ACTIVE_LOW_EN
    assign sw_in = ~switchin;
`else
    assign sw_in = switchin;
`endif

    // Stability qualification. Any cycle where the synchronised input agrees
    // with the accepted level restarts the count; there is no partial credit.
    always_comb begin
        cnt_d     = '0;
        pressed_d = ispressed;
        enabled_d = enabled;
        if (sync2_q != ispressed) begin
            if (cnt_q == CntMax) begin
                pressed_d = sync2_q;
                // Only a 0->1 acceptance toggles; releases leave enabled alone.
                if (sync2_q) begin
                    enabled_d = ~enabled;
                end
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge chatterclock or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            ispressed <= 1'b0;
            enabled   <= 1'b0;
        end else begin
            sync1_q   <= sw_in;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            ispressed <= pressed_d;
            enabled   <= enabled_d;
        end
    end

endmodule

// File: tb/tb_chatter_counter.sv
// Self-checking bench for chatter_counter with DEBOUNCE_CYCLES = 4.
// Stimulus is written in terms of the "pressed" level; the pin value is derived
// from it so the same bench covers the CHATTER_ACTIVE_LOW_EN build.

module tb_chatter_counter;

    localparam int unsigned Deb = 4;

`ifdef CHATTER_ACTIVE_LOW_EN
    localparam logic ActLow = 1'b1;
`else
    localparam logic ActLow = 1'b0;
`endif

    logic chatterclock;
    logic reset;
    logic switchin;
    logic ispressed;
    logic enabled;

    chatter_counter #(
        .DEBOUNCE_CYCLES(Deb),
        .CNT_WIDTH      (3)
    ) dut (
        .chatterclock(chatterclock),
        .reset       (reset),
        .switchin    (switchin),
        .ispressed   (ispressed),
        .enabled     (enabled)
    );

    initial chatterclock = 1'b0;
    always #5 chatterclock = ~chatterclock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural reference of the debouncer, advanced once per rising edge.
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_p = 1'b0, m_en = 1'b0;
    int   m_run = 0;  // consecutive edges on which sync2 disagreed with the level

    task automatic model_edge(input logic press, input logic rst_v);
        logic o_s1, o_s2;
        if (rst_v) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_p = 1'b0; m_en = 1'b0; m_run = 0;
        end else begin
            o_s1 = m_s1;
            o_s2 = m_s2;
            m_s1 = press;
            m_s2 = o_s1;
            if (o_s2 == m_p) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == Deb) begin
                    m_p   = o_s2;
                    m_run = 0;
                    if (o_s2) m_en = ~m_en;
                end
            end
        end
    endtask

    logic [1:0] exp_q[$];
    int   edge_no    = 0;
    int   rise_edge  = -1;
    int   fall_edge  = -1;
    logic prev_p     = 1'b0;

    // One clock: drive on the falling edge, predict at the rising edge,
    // compare 1 time unit later.
    task automatic step(input logic press, input logic rst_v);
        logic [1:0] e;
        @(negedge chatterclock);
        switchin = press ^ ActLow;
        reset    = rst_v;
        @(posedge chatterclock);
        edge_no++;
        model_edge(press, rst_v);
        exp_q.push_back({m_p, m_en});
        #1;
        e = exp_q.pop_front();
        check_eq("ispressed", int'(ispressed), int'(e[1]));
        check_eq("enabled", int'(enabled), int'(e[0]));
        if (ispressed && !prev_p) rise_edge = edge_no;
        if (!ispressed && prev_p) fall_edge = edge_no;
        prev_p = ispressed;
    endtask

    task automatic hold(input logic press, input int n);
        for (int i = 0; i < n; i++) step(press, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
        rise_edge = -1;
        fall_edge = -1;
    endtask

    int   k;
    logic bounce [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic tog_exp [3] = '{1'b1, 1'b0, 1'b1};

    initial begin
        reset    = 1'b1;
        switchin = ActLow;
        #1;
        check_eq("reset_ispressed", int'(ispressed), 0);
        check_eq("reset_enabled", int'(enabled), 0);

        // Reset held while the pin toggles freely: outputs stay 0.
        for (int i = 0; i < 8; i++) step(logic'($urandom_range(0, 1)), 1'b1);
        do_reset(1);
        hold(1'b0, 8);
        check_eq("idle_no_rise", rise_edge, -1);

        // Clean press: both outputs change exactly at edge k+5.
        step(1'b1, 1'b0);
        k = edge_no;
        hold(1'b1, 9);
        check_eq("press_latency", rise_edge - k, Deb + 1);
        check_eq("press_enabled", int'(enabled), 1);
        // Release: same latency, enabled unchanged.
        step(1'b0, 1'b0);
        k = edge_no;
        hold(1'b0, 9);
        check_eq("release_latency", fall_edge - k, Deb + 1);
        check_eq("release_enabled", int'(enabled), 1);

        // Bounce: a one-cycle dropout restarts qualification.
        do_reset(2);
        hold(1'b0, 3);
        k = edge_no + 1;
        for (int i = 0; i < 9; i++) step(bounce[i], 1'b0);
        hold(1'b1, 4);
        check_eq("bounce_latency", rise_edge - k, 9);
        hold(1'b0, 10);

        // Short pulse (3 cycles) must be rejected.
        do_reset(1);
        hold(1'b1, 3);
        hold(1'b0, 10);
        check_eq("short_pulse", rise_edge, -1);

        // Toggle sequence: enabled goes 1,0,1 across three presses.
        do_reset(1);
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 1'b0);
            k = edge_no;
            hold(1'b1, 9);
            check_eq("tog_rise_latency", rise_edge - k, Deb + 1);
            check_eq("tog_enabled", int'(enabled), int'(tog_exp[r]));
            step(1'b0, 1'b0);
            k = edge_no;
            hold(1'b0, 9);
            check_eq("tog_fall_latency", fall_edge - k, Deb + 1);
            check_eq("tog_release_en", int'(enabled), int'(tog_exp[r]));
        end

        // Mid-qualification reset aborts the change; held button re-qualifies.
        do_reset(1);
        hold(1'b0, 3);
        step(1'b1, 1'b0);
        hold(1'b1, 2);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check_eq("midreset_no_rise", rise_edge, -1);
        step(1'b1, 1'b0);
        k = edge_no;
        hold(1'b1, 9);
        check_eq("midreset_latency", rise_edge - k, Deb + 1);
        check_eq("midreset_enabled", int'(enabled), 1);

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
